// File: rtl/joypad_port_mux.sv
// joypad_port_mux
// Multi-port NES/SNES controller front-end. Per port, a button word is composed
// from debounced onboard buttons, USB HID buttons or an external serial pad,
// optionally gated by autofire, and shifted out to the NES core like a 4021:
// parallel load while strobe is high, shift right on each falling edge of the
// port read clock, 1-filled so over-reads return 1.
//
// Ports:
//   clock, R_reset   system clock, synchronous active-high reset
//   i_strobe         NES latch, level-sensitive parallel load of all ports
//   i_clk_port       per-port NES read clock, shift on falling edge
//   i_btn_board      raw onboard buttons (async, active-high)
//   i_btn_usb        USB buttons, port p at [p*C_bits +: C_bits]
//   i_ext_data       external pad serial data (async, active-low)
//   i_src_sel        per-port source: 00 board|usb, 01 usb, 10 external, 11 none
//   i_autofire_en    per-port {B,A} autofire enable
//   i_irq_ack        single-cycle IRQ clear
//   o_data           registered serial bit to NES, active-high pressed
//   o_ext_latch      passthrough of i_strobe to external pads
//   o_ext_clk        passthrough of i_clk_port to external pads
//   o_btn_state      debounced onboard buttons
//   o_irq            debounced-change interrupt
//
// IRQ protocol: o_irq rises in the cycle a debounced change is committed and
// stays high until the host pulses i_irq_ack for one cycle. No further change
// is committed while o_irq is high or during the ack cycle itself.
module joypad_port_mux #(
  parameter int C_ports         = 2,
  parameter int C_bits          = 8,
  parameter int C_debounce_bits = 20,
  parameter int C_autofire_half = 1070000
) (
  input  logic                       clock,
  input  logic                       R_reset,
  input  logic                       i_strobe,
  input  logic [C_ports-1:0]         i_clk_port,
  input  logic [C_bits-1:0]          i_btn_board,
  input  logic [C_ports*C_bits-1:0]  i_btn_usb,
  input  logic [C_ports-1:0]         i_ext_data,
  input  logic [2*C_ports-1:0]       i_src_sel,
  input  logic [2*C_ports-1:0]       i_autofire_en,
  input  logic                       i_irq_ack,
  output logic [C_ports-1:0]         o_data,
  output logic                       o_ext_latch,
  output logic [C_ports-1:0]         o_ext_clk,
  output logic [C_bits-1:0]          o_btn_state,
  output logic                       o_irq
);

  localparam int AF_W = (C_autofire_half > 1) ? $clog2(C_autofire_half) : 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(C_autofire_half - 1);
  localparam logic [AF_W-1:0] AF_ONE  = AF_W'(1);
  localparam logic [C_debounce_bits-1:0] DB_ONE = C_debounce_bits'(1);

  assign o_ext_latch = i_strobe;
  assign o_ext_clk   = i_clk_port;

  // 2-FF synchronisers for the asynchronous inputs
  logic [C_bits-1:0]  board_meta, board_sync;
  logic [C_ports-1:0] ext_meta, ext_sync;

  always_ff @(posedge clock) begin
    if (R_reset) begin
      board_meta <= '0;
      board_sync <= '0;
      ext_meta   <= '0;
      ext_sync   <= '0;
    end else begin
      board_meta <= i_btn_board;
      board_sync <= board_meta;
      ext_meta   <= i_ext_data;
      ext_sync   <= ext_meta;
    end
  end

  // Debounce: the counter runs until its MSB sets (stable window elapsed) and
  // then holds; a commit restarts the window.
  logic [C_debounce_bits-1:0] db_cnt;
  logic                       db_stable;
  logic                       db_take;

  assign db_stable = db_cnt[C_debounce_bits-1];
  assign db_take   = (board_sync != o_btn_state) && db_stable && !o_irq && !i_irq_ack;

  always_ff @(posedge clock) begin
    if (R_reset) begin
      db_cnt      <= '0;
      o_btn_state <= '0;
      o_irq       <= 1'b0;
    end else begin
      if (db_take) begin
        o_btn_state <= board_sync;
        db_cnt      <= '0;
      end else if (!db_stable) begin
        db_cnt <= db_cnt + DB_ONE;
      end
      if (i_irq_ack) begin
        o_irq <= 1'b0;
      end else if (db_take) begin
        o_irq <= 1'b1;
      end
    end
  end

  // Autofire: phase toggles every C_autofire_half cycles
  logic [AF_W-1:0] af_cnt;
  logic            af_phase;

  always_ff @(posedge clock) begin
    if (R_reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + AF_ONE;
    end
  end

  // Word composition. External/none ports still load the USB word; their
  // register output is ignored while that source is selected.
  logic [C_ports-1:0][C_bits-1:0] word;

  always_comb begin
    word = '0;
    for (int p = 0; p < C_ports; p++) begin
      if (i_src_sel[2*p +: 2] == 2'b00) begin
        word[p] = o_btn_state | i_btn_usb[p*C_bits +: C_bits];
      end else begin
        word[p] = i_btn_usb[p*C_bits +: C_bits];
      end
      if (i_autofire_en[2*p])   word[p][0] = word[p][0] & af_phase;
      if (i_autofire_en[2*p+1]) word[p][1] = word[p][1] & af_phase;
    end
  end

  // 4021-style shift registers. Edge history is cleared by reset so a read
  // clock that is low right after reset is not mistaken for a falling edge.
  logic [C_ports-1:0][C_bits-1:0] sr;
  logic [C_ports-1:0]             clk_prev;
  logic [C_ports-1:0]             clk_fall;

  assign clk_fall = clk_prev & ~i_clk_port;

  always_ff @(posedge clock) begin
    if (R_reset) begin
      sr       <= '0;
      clk_prev <= '0;
      o_data   <= '0;
    end else begin
      clk_prev <= i_clk_port;
      for (int p = 0; p < C_ports; p++) begin
        // load has priority over a coincident falling edge
        if (i_strobe) begin
          sr[p] <= word[p];
        end else if (clk_fall[p]) begin
          sr[p] <= {1'b1, sr[p][C_bits-1:1]};
        end
        case (i_src_sel[2*p +: 2])
          2'b00, 2'b01: o_data[p] <= sr[p][0];
          2'b10:        o_data[p] <= ~ext_sync[p];
          default:      o_data[p] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joypad_port_mux.sv
module tb_joypad_port_mux;
  localparam int C_PORTS  = 2;
  localparam int C_BITS   = 8;
  localparam int C_DB     = 4;
  localparam int AF_HALF  = 4;
  localparam int DB_WIN   = 1 << (C_DB - 1);

  logic                         clock;
  logic                         R_reset;
  logic                         i_strobe;
  logic [C_PORTS-1:0]           i_clk_port;
  logic [C_BITS-1:0]            i_btn_board;
  logic [C_PORTS*C_BITS-1:0]    i_btn_usb;
  logic [C_PORTS-1:0]           i_ext_data;
  logic [2*C_PORTS-1:0]         i_src_sel;
  logic [2*C_PORTS-1:0]         i_autofire_en;
  logic                         i_irq_ack;
  logic [C_PORTS-1:0]           o_data;
  logic                         o_ext_latch;
  logic [C_PORTS-1:0]           o_ext_clk;
  logic [C_BITS-1:0]            o_btn_state;
  logic                         o_irq;

  int n_vec = 0;
  int n_err = 0;

  joypad_port_mux #(
    .C_ports(C_PORTS), .C_bits(C_BITS),
    .C_debounce_bits(C_DB), .C_autofire_half(AF_HALF)
  ) dut (
    .clock(clock), .R_reset(R_reset), .i_strobe(i_strobe),
    .i_clk_port(i_clk_port), .i_btn_board(i_btn_board), .i_btn_usb(i_btn_usb),
    .i_ext_data(i_ext_data), .i_src_sel(i_src_sel), .i_autofire_en(i_autofire_en),
    .i_irq_ack(i_irq_ack), .o_data(o_data), .o_ext_latch(o_ext_latch),
    .o_ext_clk(o_ext_clk), .o_btn_state(o_btn_state), .o_irq(o_irq)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: reads are tracked as (loaded word, read position);
  // debounce as cycles since the last commit; autofire from cycles since reset.
  logic [C_BITS-1:0]  m_board_d [2];
  logic [C_PORTS-1:0] m_ext_d [2];
  logic [C_BITS-1:0]  m_btn = '0;
  logic               m_irq = 1'b0;
  int                 m_age = 0;
  int                 m_cycles = 0;
  logic [C_BITS-1:0]  m_word [C_PORTS];
  int                 m_pos [C_PORTS];
  logic [C_PORTS-1:0] m_valid = '1;
  logic [C_PORTS-1:0] m_clk_prev = '0;
  logic [C_PORTS-1:0] m_data = '0;
  logic [C_PORTS-1:0] m_known = '1;

  function automatic logic model_bit(int p);
    if (m_pos[p] >= C_BITS) return 1'b1;
    return m_word[p][m_pos[p]];
  endfunction

  function automatic logic [C_BITS-1:0] compose(int p, logic ph);
    logic [C_BITS-1:0] w;
    logic [C_BITS-1:0] usb;
    usb = i_btn_usb[p*C_BITS +: C_BITS];
    w = (i_src_sel[2*p +: 2] == 2'b00) ? (m_btn | usb) : usb;
    if (i_autofire_en[2*p] && !ph)   w[0] = 1'b0;
    if (i_autofire_en[2*p+1] && !ph) w[1] = 1'b0;
    return w;
  endfunction

  task automatic model_step();
    logic [C_PORTS-1:0] nd;
    logic [C_PORTS-1:0] nk;
    logic ph;
    logic take;
    int src;
    if (R_reset) begin
      m_board_d[0] = '0; m_board_d[1] = '0;
      m_ext_d[0] = '0;   m_ext_d[1] = '0;
      m_btn = '0; m_irq = 1'b0; m_age = 0; m_cycles = 0;
      m_clk_prev = '0; m_data = '0; m_known = '1; m_valid = '1;
      for (int p = 0; p < C_PORTS; p++) begin
        m_word[p] = '0;
        m_pos[p] = 0;
      end
      return;
    end
    ph = ((m_cycles / AF_HALF) % 2) == 1;
    for (int p = 0; p < C_PORTS; p++) begin
      src = int'(i_src_sel[2*p +: 2]);
      if (src < 2) begin
        nd[p] = model_bit(p);
        nk[p] = m_valid[p];
      end else begin
        nd[p] = (src == 2) ? ~m_ext_d[1][p] : 1'b0;
        nk[p] = 1'b1;
      end
      if (i_strobe) begin
        m_word[p] = compose(p, ph);
        m_pos[p] = 0;
        m_valid[p] = (src < 2);
      end else if (m_clk_prev[p] && !i_clk_port[p] && m_pos[p] < C_BITS) begin
        m_pos[p]++;
      end
    end
    m_clk_prev = i_clk_port;
    take = (m_board_d[1] != m_btn) && (m_age >= DB_WIN) && !m_irq && !i_irq_ack;
    if (take) begin
      m_btn = m_board_d[1];
      m_age = 0;
    end else begin
      m_age++;
    end
    if (i_irq_ack) m_irq = 1'b0;
    else if (take) m_irq = 1'b1;
    m_board_d[1] = m_board_d[0]; m_board_d[0] = i_btn_board;
    m_ext_d[1] = m_ext_d[0];     m_ext_d[0] = i_ext_data;
    m_cycles++;
    m_data = nd;
    m_known = nk;
  endtask

  // driver: advance one clock, outputs are stable at the following negedge
  task automatic cyc();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    R_reset = 1'b1;
    repeat (3) cyc();
    n_vec++; if (o_data !== 2'b00) begin n_err++; $display("FAIL reset_data: got %b expected 00", o_data); end
    n_vec++; if (o_btn_state !== 8'h00) begin n_err++; $display("FAIL reset_btn: got %h expected 00", o_btn_state); end
    n_vec++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", o_irq); end
    R_reset = 1'b0;
    cyc();
  endtask

  task automatic test_serial_read();
    logic [9:0] seq;
    seq = 10'b1110000001;
    i_btn_usb[7:0] = 8'h81;
    i_src_sel[1:0] = 2'b01;
    i_strobe = 1'b1; cyc();
    i_strobe = 1'b0; cyc();
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (o_data[0] !== seq[i]) begin
        n_err++; $display("FAIL serial_bit%0d: got %b expected %b", i, o_data[0], seq[i]);
      end
      i_clk_port[0] = 1'b1; cyc();
      i_clk_port[0] = 1'b0; cyc(); cyc();
    end
    n_vec++; if (o_data[0] !== 1'b1) begin n_err++; $display("FAIL serial_overread: got %b expected 1", o_data[0]); end
  endtask

  task automatic test_debounce();
    int waited;
    i_btn_board = 8'h08;
    waited = 0;
    while (o_irq !== 1'b1 && waited < 40) begin
      cyc(); waited++;
      n_vec++;
      if (o_btn_state !== m_btn || o_irq !== m_irq) begin
        n_err++; $display("FAIL deb_model: got %h/%b expected %h/%b", o_btn_state, o_irq, m_btn, m_irq);
      end
    end
    n_vec++; if (waited != 3) begin n_err++; $display("FAIL deb_latency: got %0d expected 3", waited); end
    n_vec++; if (o_btn_state !== 8'h08) begin n_err++; $display("FAIL deb_state: got %h expected 08", o_btn_state); end
    // change while IRQ pending is ignored
    i_btn_board = 8'h00;
    repeat (20) cyc();
    n_vec++; if (o_btn_state !== 8'h08 || o_irq !== 1'b1) begin
      n_err++; $display("FAIL deb_pending: got %h/%b expected 08/1", o_btn_state, o_irq);
    end
    // ack cycle blocks the commit, the next cycle takes it
    i_irq_ack = 1'b1; cyc(); i_irq_ack = 1'b0;
    n_vec++; if (o_irq !== 1'b0 || o_btn_state !== 8'h08) begin
      n_err++; $display("FAIL deb_ack: got %h/%b expected 08/0", o_btn_state, o_irq);
    end
    cyc();
    n_vec++; if (o_irq !== 1'b1 || o_btn_state !== 8'h00) begin
      n_err++; $display("FAIL deb_after_ack: got %h/%b expected 00/1", o_btn_state, o_irq);
    end
    // immediate ack and change: commit only after the stability window
    i_irq_ack = 1'b1; i_btn_board = 8'h08; cyc(); i_irq_ack = 1'b0;
    waited = 0;
    while (o_btn_state !== 8'h08 && waited < 40) begin
      cyc(); waited++;
      n_vec++;
      if (o_btn_state !== m_btn || o_irq !== m_irq) begin
        n_err++; $display("FAIL deb_model2: got %h/%b expected %h/%b", o_btn_state, o_irq, m_btn, m_irq);
      end
    end
    n_vec++; if (waited != DB_WIN) begin n_err++; $display("FAIL deb_window: got %0d expected %0d", waited, DB_WIN); end
    i_irq_ack = 1'b1; cyc(); i_irq_ack = 1'b0;
  endtask

  task automatic test_strobe_priority();
    i_btn_usb[15:8] = 8'h02;
    i_src_sel[3:2] = 2'b01;
    i_strobe = 1'b1; cyc();
    i_clk_port[1] = 1'b1; cyc();
    i_clk_port[1] = 1'b0; cyc(); cyc();
    n_vec++; if (o_data[1] !== 1'b0) begin n_err++; $display("FAIL strobe_hold: got %b expected 0", o_data[1]); end
    i_strobe = 1'b0; cyc(); cyc();
    n_vec++; if (o_data[1] !== 1'b0) begin n_err++; $display("FAIL strobe_release: got %b expected 0", o_data[1]); end
    i_clk_port[1] = 1'b1; cyc();
    i_clk_port[1] = 1'b0; cyc(); cyc();
    n_vec++; if (o_data[1] !== 1'b1) begin n_err++; $display("FAIL strobe_shift: got %b expected 1", o_data[1]); end
  endtask

  task automatic test_autofire();
    logic s [24];
    int last;
    int runs;
    i_src_sel[1:0] = 2'b01;
    i_btn_usb[7:0] = 8'h01;
    i_autofire_en = 4'b0001;
    i_strobe = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 24; i++) begin
      cyc();
      s[i] = o_data[0];
      n_vec++;
      if (o_data[0] !== m_data[0]) begin
        n_err++; $display("FAIL af_model%0d: got %b expected %b", i, o_data[0], m_data[0]);
      end
    end
    last = -1; runs = 0;
    for (int i = 1; i < 24; i++) begin
      if (s[i] !== s[i-1]) begin
        if (last >= 0) begin
          n_vec++; runs++;
          if (i - last != AF_HALF) begin
            n_err++; $display("FAIL af_run: got %0d expected %0d", i - last, AF_HALF);
          end
        end
        last = i;
      end
    end
    n_vec++; if (runs < 3) begin n_err++; $display("FAIL af_toggles: got %0d expected >=3", runs); end
    i_strobe = 1'b0;
    i_autofire_en = 4'b0000;
    cyc();
  endtask

  task automatic test_external();
    i_ext_data = 2'b11;
    i_src_sel[3:2] = 2'b10;
    repeat (3) cyc();
    n_vec++; if (o_data[1] !== 1'b0) begin n_err++; $display("FAIL ext_idle: got %b expected 0", o_data[1]); end
    i_ext_data[1] = 1'b0;
    cyc(); cyc();
    n_vec++; if (o_data[1] !== 1'b0) begin n_err++; $display("FAIL ext_early: got %b expected 0", o_data[1]); end
    cyc();
    n_vec++; if (o_data[1] !== 1'b1) begin n_err++; $display("FAIL ext_pressed: got %b expected 1", o_data[1]); end
    i_src_sel[3:2] = 2'b11;
    cyc();
    n_vec++; if (o_data[1] !== 1'b0) begin n_err++; $display("FAIL ext_none: got %b expected 0", o_data[1]); end
    i_ext_data = 2'b11;
  endtask

  task automatic test_reset_mid_read();
    i_btn_board = 8'h00;
    i_src_sel = 4'b0101;
    i_btn_usb[7:0] = 8'h2E;
    i_strobe = 1'b1; cyc();
    i_strobe = 1'b0; cyc();
    repeat (3) begin
      i_clk_port[0] = 1'b1; cyc();
      i_clk_port[0] = 1'b0; cyc();
    end
    cyc();
    n_vec++; if (o_data[0] !== 1'b1) begin n_err++; $display("FAIL mid_bit3: got %b expected 1", o_data[0]); end
    i_clk_port[0] = 1'b1;
    R_reset = 1'b1; cyc();
    n_vec++; if (o_data !== 2'b00 || o_btn_state !== 8'h00 || o_irq !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got %b/%h/%b expected 00/00/0", o_data, o_btn_state, o_irq);
    end
    R_reset = 1'b0; i_clk_port[0] = 1'b0; cyc();
    // 7 genuine shifts of a cleared register leave bit0 at 0; the 8th brings a 1
    repeat (7) begin
      i_clk_port[0] = 1'b1; cyc();
      i_clk_port[0] = 1'b0; cyc();
    end
    cyc();
    n_vec++; if (o_data[0] !== 1'b0) begin n_err++; $display("FAIL mid_no_ghost: got %b expected 0", o_data[0]); end
    i_clk_port[0] = 1'b1; cyc();
    i_clk_port[0] = 1'b0; cyc(); cyc();
    n_vec++; if (o_data[0] !== 1'b1) begin n_err++; $display("FAIL mid_fill: got %b expected 1", o_data[0]); end
    i_strobe = 1'b1; cyc();
    i_strobe = 1'b0; cyc();
    n_vec++; if (o_data[0] !== 1'b0) begin n_err++; $display("FAIL mid_reload_b0: got %b expected 0", o_data[0]); end
    i_clk_port[0] = 1'b1; cyc();
    i_clk_port[0] = 1'b0; cyc(); cyc();
    n_vec++; if (o_data[0] !== 1'b1) begin n_err++; $display("FAIL mid_reload_b1: got %b expected 1", o_data[0]); end
  endtask

  task automatic test_random();
    int seg_left;
    seg_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        seg_left = $urandom_range(20, 80);
        for (int p = 0; p < C_PORTS; p++) begin
          if ($urandom_range(0, 9) < 7) i_src_sel[2*p +: 2] = 2'($urandom_range(0, 1));
          else                          i_src_sel[2*p +: 2] = 2'($urandom_range(2, 3));
        end
        i_btn_usb = 16'($urandom);
        i_autofire_en = 4'($urandom_range(0, 15));
      end
      seg_left--;
      i_strobe = (i_src_sel[1] == 1'b0) && (i_src_sel[3] == 1'b0) && ($urandom_range(0, 15) == 0);
      i_clk_port = i_clk_port ^ 2'($urandom_range(0, 3));
      i_ext_data = 2'($urandom_range(0, 3));
      i_irq_ack = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) i_btn_board = 8'($urandom);
      #1;
      n_vec++;
      if (o_ext_latch !== i_strobe || o_ext_clk !== i_clk_port) begin
        n_err++; $display("FAIL rnd_pass: got %b/%b expected %b/%b", o_ext_latch, o_ext_clk, i_strobe, i_clk_port);
      end
      cyc();
      n_vec++;
      if (o_btn_state !== m_btn || o_irq !== m_irq) begin
        n_err++; $display("FAIL rnd_deb c%0d: got %h/%b expected %h/%b", c, o_btn_state, o_irq, m_btn, m_irq);
      end
      for (int p = 0; p < C_PORTS; p++) begin
        if (m_known[p]) begin
          n_vec++;
          if (o_data[p] !== m_data[p]) begin
            n_err++; $display("FAIL rnd_data c%0d p%0d: got %b expected %b", c, p, o_data[p], m_data[p]);
          end
        end
      end
    end
    i_irq_ack = 1'b0;
    i_strobe = 1'b0;
  endtask

  initial begin
    R_reset = 1'b1;
    i_strobe = 1'b0;
    i_clk_port = '0;
    i_btn_board = '0;
    i_btn_usb = '0;
    i_ext_data = '1;
    i_src_sel = '0;
    i_autofire_en = '0;
    i_irq_ack = 1'b0;
    test_reset();
    test_serial_read();
    test_debounce();
    test_strobe_priority();
    test_autofire();
    test_external();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/joypad_port_mux.md
Name: joypad_port_mux

Overview:
- Parametrised multi-port NES/SNES controller front-end: replaces the single-port 8-bit joypad shift logic in the top level.
- Per port, composes a button word from onboard buttons, USB HID buttons or an external serial pad, with optional autofire, and serialises it to the NES core on strobe/clock like a 4021 shift register.
- Also debounces onboard buttons and raises an IRQ for the ESP32 on debounced change.

Parameters:
- C_ports, 2, number of controller ports (1..4).
- C_bits, 8, bits per controller word (8 NES, 16 SNES); bit0 is shifted out first.
- C_debounce_bits, 20, width of the debounce counter; its MSB set means the button state is stable.
- C_autofire_half, 1070000, clock cycles per autofire half-period (≈10 Hz at 21.4 MHz); minimum 1.

Ports:
- clock  in  1  system clock (NES clock domain).
- R_reset  in  1  synchronous reset, active-high.
- i_strobe  in  1  NES latch (joy_strobe); level-sensitive parallel load.
- i_clk_port  in  C_ports  NES per-port read clock; shift on falling edge.
- i_btn_board  in  C_bits  raw onboard buttons, asynchronous, active-high.
- i_btn_usb  in  C_ports*C_bits  USB decoder buttons, clock-synchronous, active-high; port p at [p*C_bits +: C_bits].
- i_ext_data  in  C_ports  external pad serial data, asynchronous, active-low.
- i_src_sel  in  2*C_ports  per-port source: 00 board|usb, 01 usb only, 10 external, 11 none.
- i_autofire_en  in  2*C_ports  per port {B,A} autofire enable.
- i_irq_ack  in  1  single-cycle IRQ clear.
- o_data  out  C_ports  serial button bit to NES, active-high pressed.
- o_ext_latch  out  1  = i_strobe (combinational passthrough).
- o_ext_clk  out  C_ports  = i_clk_port (combinational passthrough).
- o_btn_state  out  C_bits  debounced onboard buttons.
- o_irq  out  1  change interrupt, active-high (top inverts for wifi_gpio0).

Behaviour:
Clock/reset
- Clock is clock; reset R_reset, synchronous, active-high.
- Reset values: o_data=0, o_btn_state=0, o_irq=0, all shift registers 0, debounce counter 0, autofire counter 0, autofire phase 0, synchronisers 0, clock-edge history 0.

Synchronisation
- i_btn_board and i_ext_data pass through 2-FF synchronisers, giving 2 cycles of latency.

Debounce
- Counter increments while its MSB is 0 and saturates once MSB=1.
- If the synced board value differs from o_btn_state, MSB=1, o_irq=0 and i_irq_ack=0: o_btn_state takes the synced value, the counter clears and o_irq sets, all in the same cycle.
- i_irq_ack=1 clears o_irq. Ack has priority: a change in the ack cycle is not taken and is re-evaluated next cycle.
- Consequence: at most one update per stability window, and none while the IRQ is pending.

Autofire
- Free-running counter 0..C_autofire_half-1; at wrap, phase toggles.
- Enabled A (word bit0) or B (word bit1) is ANDed with phase; other bits are unaffected.

Word composition, per port p
- 00: o_btn_state | usb[p].
- 01: usb[p].
- Autofire is applied after the source mux.

Shift register, per port p
- While i_strobe=1: the register loads the composed word every cycle.
- Otherwise, on a falling edge of i_clk_port[p] (previous=1, current=0): shift right, MSB filled with 1, so reads beyond C_bits return 1 as on real 4021 hardware.
- Strobe and falling edge in the same cycle: load wins.
- o_data[p] is registered, updated the cycle after the register changes:
  - src 00/01: sr[0].
  - src 10: ~synced i_ext_data[p].
  - src 11: 0.
- A src change takes effect on o_data in the next cycle; the register contents are kept.
- A source switch mid-read does not reload; the next strobe reloads.

Reset mid-read
- Registers clear to 0.
- Edge history clears, so a low i_clk_port after reset causes no shift.

Test Plan:
- Reset, then usb[0]=8'h81, src0=01, strobe pulse, then 10 falling edges of i_clk_port[0] -> o_data[0] sequence 1,0,0,0,0,0,0,1,1,1 (1-fill after bit 7).
- i_btn_board=8'h08, C_debounce_bits=4, src0=00 -> o_btn_state=8'h08 and o_irq=1 once the counter MSB is set. Toggle board input again with the IRQ pending -> no update. i_irq_ack pulse -> o_irq=0, and the next change is taken after the window.
- Strobe held high while a falling edge of i_clk_port[1] occurs, usb[1]=8'h02, src1=01 -> no shift; o_data[1]=0 (bit0), and after strobe low plus one edge o_data[1]=1.
- C_autofire_half=4, src0=01, usb[0]=8'h01, autofire A on, strobe every cycle -> o_data[0] alternates 4 cycles 1 / 4 cycles 0.
- src1=10, i_ext_data[1] driven 0 -> o_data[1]=1 three cycles later (2-FF sync plus output register). src1=11 -> o_data[1]=0 the following cycle.
- R_reset asserted after 3 shifts -> all outputs 0 next cycle; a subsequent strobe reloads the full word, and the read restarts at bit0.
